// File: rtl/yadan_pipe_pkg.sv
// rtl/yadan_pipe_pkg.sv - shared pipeline payload types and NOP constants
//
// Purpose: payload structs carried between pipeline stages, their packed
//          widths, the NOP field encodings and the entry-register opcode
//          used by pipe_skid_entry.
// Ports:   none (package).

package yadan_pipe_pkg;

  // NOP instruction field encodings
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [7:0]  EXE_NONE     = 8'h00;

  typedef struct packed {
    logic        wreg;      // register write enable
    logic [4:0]  wd;        // destination register
    logic [31:0] wdata;     // result to write back
    logic [7:0]  aluop;     // memory-stage operation
    logic [31:0] mem_addr;  // load/store address
    logic [31:0] reg2;      // store data
  } ex_mem_t;

  typedef struct packed {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
  } mem_wb_t;

  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

  localparam ex_mem_t EX_MEM_NOP = '{
    wreg:     WriteDisable,
    wd:       NOPRegAddr,
    wdata:    ZeroWord,
    aluop:    EXE_NONE,
    mem_addr: ZeroWord,
    reg2:     ZeroWord
  };

  localparam mem_wb_t MEM_WB_NOP = '{
    wreg:  WriteDisable,
    wd:    NOPRegAddr,
    wdata: ZeroWord
  };

  // Per-cycle command for one valid+data entry register
  typedef enum logic [1:0] {
    ENT_HOLD  = 2'd0,
    ENT_LOAD  = 2'd1,
    ENT_CLEAR = 2'd2
  } ent_op_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// rtl/pipe_skid_entry.sv - one valid+data entry register with load/clear
//
// Purpose: holds a single payload word and its valid bit. An empty entry
//          always holds CLR_VALUE so downstream sees a clean bubble.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (-> empty, CLR_VALUE)
//   op         in   ENT_HOLD / ENT_LOAD / ENT_CLEAR
//   load_valid in   valid bit to load on ENT_LOAD
//   load_data  in   data to load on ENT_LOAD (ignored when load_valid=0)
//   valid      out  entry holds a real payload
//   data       out  entry payload, CLR_VALUE when empty

module pipe_skid_entry
  import yadan_pipe_pkg::*;
#(
  parameter int unsigned     W         = 64,
  parameter logic [W-1:0]    CLR_VALUE = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  ent_op_e      op,
  input  logic         load_valid,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    case (op)
      ENT_LOAD: begin
        valid_d = load_valid;
        // an invalid load is a bubble: force the NOP pattern
        data_d  = load_valid ? load_data : CLR_VALUE;
      end
      ENT_CLEAR: begin
        valid_d = 1'b0;
        data_d  = CLR_VALUE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= CLR_VALUE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready pipeline stage with 2-entry skid buffer
//
// Purpose: carries an opaque payload between two stages. A main entry drives
//          the outputs; a skid entry absorbs the word accepted while the
//          downstream stalls, so in_ready comes straight from a flop. Empty
//          cycles present NOP_VALUE. flush kills both entries.
// Optional: PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             synchronous kill of both entries
//   in_valid/in_ready/in_data      upstream handshake and payload
//   out_valid/out_ready/out_data   downstream handshake and payload
//   perf_stall_cnt    cycles with out_valid=1, out_ready=0 (perf build)
//   perf_bubble_cnt   cycles with out_valid=0 (perf build)

module pipe_stage_buf
  import yadan_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int unsigned       PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPE_STAGE_PERF_EN
  output logic [DATA_W-1:0] out_data,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_bubble_cnt
`else
  output logic [DATA_W-1:0] out_data
`endif
);

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;

  ent_op_e           main_op,       skid_op;
  logic              main_ld_valid, skid_ld_valid;
  logic [DATA_W-1:0] main_ld_data,  skid_ld_data;
  logic              skid_valid_nxt;

  logic              in_ready_q, in_ready_d;
  logic              consume, accept;

  always_comb begin
    consume        = out_valid & out_ready;
    accept         = in_valid & in_ready_q;
    main_op        = ENT_HOLD;
    skid_op        = ENT_HOLD;
    main_ld_valid  = 1'b0;
    skid_ld_valid  = 1'b0;
    main_ld_data   = in_data;
    skid_ld_data   = in_data;
    skid_valid_nxt = skid_valid;

    if (flush) begin
      // a same-cycle consume has already completed downstream; any
      // accepted input is simply dropped
      main_op        = ENT_CLEAR;
      skid_op        = ENT_CLEAR;
      skid_valid_nxt = 1'b0;
    end else if (!out_valid || consume) begin
      main_op = ENT_LOAD;
      if (skid_valid) begin
        // skid is older than anything arriving now: promote it first
        main_ld_valid  = 1'b1;
        main_ld_data   = skid_data;
        skid_op        = ENT_LOAD;
        skid_ld_valid  = accept;
        skid_valid_nxt = accept;
      end else begin
        // no input means a bubble (entry loads NOP_VALUE)
        main_ld_valid = accept;
      end
    end else if (accept) begin
      skid_op        = ENT_LOAD;
      skid_ld_valid  = 1'b1;
      skid_valid_nxt = 1'b1;
    end

    in_ready_d = ~skid_valid_nxt;
  end

  pipe_skid_entry #(
    .W         (DATA_W),
    .CLR_VALUE (NOP_VALUE)
  ) u_main (
    .clk        (clk),
    .rst        (rst),
    .op         (main_op),
    .load_valid (main_ld_valid),
    .load_data  (main_ld_data),
    .valid      (out_valid),
    .data       (out_data)
  );

  pipe_skid_entry #(
    .W         (DATA_W),
    .CLR_VALUE (NOP_VALUE)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .op         (skid_op),
    .load_valid (skid_ld_valid),
    .load_data  (skid_ld_data),
    .valid      (skid_valid),
    .data       (skid_data)
  );

  // dedicated flop so upstream never sees a combinational path from out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [PERF_W-1:0] stall_q,  stall_d;
  logic [PERF_W-1:0] bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && (stall_q != {PERF_W{1'b1}})) begin
      stall_d = stall_q + PERF_W'(1);
    end
    if (!out_valid && (bubble_q != {PERF_W{1'b1}})) begin
      bubble_d = bubble_q + PERF_W'(1);
    end
  end

  // cleared by rst only; flush does not touch the statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign perf_stall_cnt  = stall_q;
  assign perf_bubble_cnt = bubble_q;
`else
  if (PERF_W == 0) begin : g_perf_w_unused
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf

module tb_pipe_stage_buf;

  localparam int unsigned       DW   = 16;
  localparam logic [DW-1:0]     NOP  = 16'hA5A5;
  localparam int unsigned       PW   = 4;
  localparam int unsigned       PMAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [PW-1:0] perf_stall_cnt;
  logic [PW-1:0] perf_bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // reference: FIFO of held words (capacity 2) plus counter values
  logic [DW-1:0] mq[$];
  int unsigned   m_stall  = 0;
  int unsigned   m_bubble = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .DATA_W    (DW),
    .NOP_VALUE (NOP),
    .PERF_W    (PW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
`ifdef PIPE_STAGE_PERF_EN
    .out_data        (out_data),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`else
    .out_data        (out_data)
`endif
  );

  // Drive one cycle of inputs, advance the model across the edge, and
  // return #1 after the edge so outputs can be sampled.
  task automatic tick(input logic iv, input logic [DW-1:0] id,
                      input logic ordy, input logic fl, input logic rs);
    logic cons, acc;
    rst       = rs;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(posedge clk);
    cons = (mq.size() > 0) && ordy;
    acc  = iv && (mq.size() < 2);
    if (rs) begin
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (mq.size() > 0 && !ordy && m_stall < PMAX) m_stall++;
      if (mq.size() == 0 && m_bubble < PMAX) m_bubble++;
    end
    if (rs || fl) begin
      mq.delete();
    end else begin
      if (cons) void'(mq.pop_front());
      if (acc) mq.push_back(id);
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 16'h00AB, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 16'h00AB, 1'b1, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== NOP) begin bad++; $display("FAIL reset_out_data got=%h exp=%h", out_data, NOP); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tick(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_nothing_accepted got=%b exp=0", out_valid); end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 16; i++) begin
      tick(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
      total++;
      if (out_valid !== 1'b1 || out_data !== DW'(i) || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_%0d got v=%b d=%h r=%b exp v=1 d=%h r=1", i, out_valid, out_data, in_ready, DW'(i));
      end
    end
    tick(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b0 || out_data !== NOP) begin bad++; $display("FAIL stream_tail got v=%b d=%h exp v=0 d=%h", out_valid, out_data, NOP); end
  endtask

  task automatic test_back_pressure();
    tick(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    total++; if (out_data !== 16'h0001 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_skid_full got d=%h r=%b exp d=0001 r=0", out_data, in_ready); end
    tick(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 16'h0001 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold got v=%b d=%h r=%b exp v=1 d=0001 r=0", out_valid, out_data, in_ready); end
    tick(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
    total++; if (out_data !== 16'h0002 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release1 got d=%h r=%b exp d=0002 r=1", out_data, in_ready); end
    tick(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 16'h0003) begin bad++; $display("FAIL bp_release2 got v=%b d=%h exp v=1 d=0003", out_valid, out_data); end
    tick(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b0 || out_data !== NOP) begin bad++; $display("FAIL bp_no_dup got v=%b d=%h exp v=0 d=%h", out_valid, out_data, NOP); end
  endtask

  task automatic test_flush();
    tick(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 16'h0007, 1'b0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0 || out_data !== NOP || in_ready !== 1'b1) begin bad++; $display("FAIL flush_full got v=%b d=%h r=%b exp v=0 d=%h r=1", out_valid, out_data, in_ready, NOP); end
    tick(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop7 got v=%b d=%h exp v=0", out_valid, out_data); end
    tick(1'b1, 16'h0008, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 16'h0009, 1'b1, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0 || out_data !== NOP || in_ready !== 1'b1) begin bad++; $display("FAIL flush_accept got v=%b d=%h r=%b exp v=0 d=%h r=1", out_valid, out_data, in_ready, NOP); end
  endtask

  task automatic test_drain();
    tick(1'b1, 16'h0022, 1'b1, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 16'h0022) begin bad++; $display("FAIL drain_word got v=%b d=%h exp v=1 d=0022", out_valid, out_data); end
    tick(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b0 || out_data !== NOP) begin bad++; $display("FAIL drain_bubble got v=%b d=%h exp v=0 d=%h", out_valid, out_data, NOP); end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 600; i++) begin
      tick(logic'($urandom_range(0, 3) != 0), DW'($urandom),
           logic'($urandom_range(0, 2) != 0),
           logic'($urandom_range(0, 19) == 0),
           logic'($urandom_range(0, 79) == 0));
      exp_d = (mq.size() > 0) ? mq[0] : NOP;
      total++;
      if (out_valid !== (mq.size() > 0) || out_data !== exp_d || in_ready !== (mq.size() < 2)) begin
        bad++;
        $display("FAIL random_%0d got v=%b d=%h r=%b exp v=%b d=%h r=%b", i, out_valid, out_data, in_ready,
                 mq.size() > 0, exp_d, mq.size() < 2);
      end
`ifdef PIPE_STAGE_PERF_EN
      total++;
      if (perf_stall_cnt !== PW'(m_stall) || perf_bubble_cnt !== PW'(m_bubble)) begin
        bad++;
        $display("FAIL random_perf_%0d got s=%0d b=%0d exp s=%0d b=%0d", i, perf_stall_cnt, perf_bubble_cnt, m_stall, m_bubble);
      end
`endif
    end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'h0031, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    total++; if (perf_stall_cnt !== 4'hF) begin bad++; $display("FAIL perf_saturate got=%h exp=F", perf_stall_cnt); end
    total++; if (perf_bubble_cnt !== 4'h1) begin bad++; $display("FAIL perf_bubble got=%h exp=1", perf_bubble_cnt); end
    tick(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    total++; if (perf_stall_cnt !== 4'hF) begin bad++; $display("FAIL perf_flush_keep got=%h exp=F", perf_stall_cnt); end
    tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    total++; if (perf_stall_cnt !== 4'h0 || perf_bubble_cnt !== 4'h0) begin bad++; $display("FAIL perf_rst got s=%h b=%h exp 0 0", perf_stall_cnt, perf_bubble_cnt); end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_drain();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
